// File: rtl/dino_pkg.sv
// Shared types and constants for the dino runner game core.
// Covers game state encoding, phase limit and LFSR parameters.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } game_st_t;

  localparam logic [2:0] PHASE_MAX = 3'd5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] SEED_DEF  = 8'hA5;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s
  );
    lfsr_next = s >> 1;
    if (s[0]) lfsr_next = lfsr_next ^ LFSR_TAPS;
  endfunction

endpackage

// File: rtl/dino_lfsr.sv
// 8-bit Galois LFSR with synchronous seed load and step enable.
// Reset and load both return the register to the seed value.
module dino_lfsr
  import dino_pkg::*;
#(
  parameter logic [7:0] SEED = SEED_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_en,
  output logic [7:0] o_q
);

  logic [7:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_load) begin
      r_q <= SEED;
    end else if (i_en) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/obstacle_track.sv
// Obstacle lane, jump timer, score and IDLE/RUN/OVER game FSM.
// One game step per change of the upstream phase counter.
module obstacle_track
  import dino_pkg::*;
#(
  parameter int         LANE_LEN  = 16,
  parameter int         MIN_GAP   = 3,
  parameter int         AIR_TICKS = 4,
  parameter logic [7:0] LFSR_SEED = SEED_DEF,
  parameter int         SCORE_W   = 10
) (
  input  logic                C,
  input  logic                rst_n,
  input  logic [2:0]          phase,
  input  logic                jump_btn,
  input  logic                start_btn,
  output logic [LANE_LEN-1:0] lane,
  output logic                dino_air,
  output logic                game_over,
  output logic                running,
  output logic [SCORE_W-1:0]  score,
  output logic                step
);

  localparam int AW = $clog2(AIR_TICKS + 1);
  localparam int GW = $clog2(MIN_GAP + 1);

  game_st_t            r_state;
  game_st_t            w_state_nx;
  logic [LANE_LEN-1:0] r_lane;
  logic [LANE_LEN-1:0] w_lane_nx;
  logic [SCORE_W-1:0]  r_score;
  logic [SCORE_W-1:0]  w_score_nx;
  logic [AW-1:0]       r_air;
  logic [AW-1:0]       w_air_nx;
  logic [GW-1:0]       r_gap;
  logic [GW-1:0]       w_gap_nx;
  logic [2:0]          r_phase_q;
  logic                r_jump_q;
  logic                r_start_q;

  logic [7:0] w_lfsr;
  logic       w_phase_ok;
  logic       w_raw_step;
  logic       w_jump_rise;
  logic       w_start_rise;
  logic       w_air;
  logic       w_collide;
  logic       w_spawn;
  logic       w_restart;
  logic       w_adv;

  assign w_phase_ok   = (phase <= PHASE_MAX);
  assign w_raw_step   = (phase != r_phase_q) && w_phase_ok;
  assign w_jump_rise  = jump_btn & ~r_jump_q;
  assign w_start_rise = start_btn & ~r_start_q;
  assign w_air        = (r_air != '0);
  assign w_collide    = r_lane[0] && !w_air;
  assign w_spawn      = (w_lfsr[1:0] == 2'b00)
                     && (r_gap >= GW'(MIN_GAP));
  assign w_restart    = w_start_rise && (r_state != ST_RUN);
  assign w_adv        = (r_state == ST_RUN)
                     && !w_collide && w_raw_step;

  // Spawn uses the pre-advance value, so the LFSR steps with the lane.
  dino_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (C),
    .i_rst_n (rst_n),
    .i_load  (w_restart),
    .i_en    (w_adv),
    .o_q     (w_lfsr)
  );

  always_comb begin
    w_state_nx = r_state;
    w_lane_nx  = r_lane;
    w_score_nx = r_score;
    w_air_nx   = r_air;
    w_gap_nx   = r_gap;
    unique case (r_state)
      ST_RUN: begin
        if (w_collide) begin
          w_state_nx = ST_OVER;
        end else begin
          if (w_raw_step) begin
            w_lane_nx = {w_spawn, r_lane[LANE_LEN-1:1]};
            if (r_lane[0] && (r_score != '1))
              w_score_nx = r_score + 1'b1;
            if (w_spawn)
              w_gap_nx = '0;
            else if (r_gap < GW'(MIN_GAP))
              w_gap_nx = r_gap + 1'b1;
            if (w_air)
              w_air_nx = r_air - 1'b1;
          end
          // Gated on the pre-step timer: a 1->0 landing eats the press.
          if (w_jump_rise && !w_air)
            w_air_nx = AW'(AIR_TICKS);
        end
      end
      ST_IDLE, ST_OVER: begin
        if (w_start_rise) begin
          w_state_nx = ST_RUN;
          w_lane_nx  = '0;
          w_score_nx = '0;
          w_air_nx   = '0;
          w_gap_nx   = '0;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lane    <= '0;
      r_score   <= '0;
      r_air     <= '0;
      r_gap     <= '0;
      r_phase_q <= phase;
      r_jump_q  <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_lane    <= w_lane_nx;
      r_score   <= w_score_nx;
      r_air     <= w_air_nx;
      r_gap     <= w_gap_nx;
      if (w_phase_ok)
        r_phase_q <= phase;
      r_jump_q  <= jump_btn;
      r_start_q <= start_btn;
    end
  end

  assign lane      = r_lane;
  assign dino_air  = w_air;
  assign game_over = (r_state == ST_OVER);
  assign running   = (r_state == ST_RUN);
  assign score     = r_score;
  assign step      = w_raw_step && (r_state == ST_RUN);

endmodule

// File: tb/tb_obstacle_track.sv
// Bench for obstacle_track: a game model feeds an expected-state
// scoreboard; a second instance uses a 2-bit score to hit saturation.
module tb_obstacle_track;

  localparam int LL = 16;
  typedef logic [49:0] vec_t;

  logic          C = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    phase = 3'd3;
  logic          jump_btn = 1'b0;
  logic          start_btn = 1'b0;
  logic [LL-1:0] lane, lane2;
  logic          dino_air, game_over, running, step;
  logic          dino_air2, game_over2, running2, step2;
  logic [9:0]    score;
  logic [1:0]    score2;

  always #5 C = ~C;

  obstacle_track #(.SCORE_W(10)) dut (
    .C (C), .rst_n (rst_n), .phase (phase),
    .jump_btn (jump_btn), .start_btn (start_btn),
    .lane (lane), .dino_air (dino_air),
    .game_over (game_over), .running (running),
    .score (score), .step (step)
  );

  obstacle_track #(.SCORE_W(2)) dut2 (
    .C (C), .rst_n (rst_n), .phase (phase),
    .jump_btn (jump_btn), .start_btn (start_btn),
    .lane (lane2), .dino_air (dino_air2),
    .game_over (game_over2), .running (running2),
    .score (score2), .step (step2)
  );

  int n_pass = 0;
  int n_chk = 0;
  int step_cnt = 0;
  int step_cnt2 = 0;
  int step_base = 0;
  int step_base2 = 0;

  always @(negedge C) begin
    if (step === 1'b1) step_cnt++;
    if (step2 === 1'b1) step_cnt2++;
  end

  // game model: 0 idle, 1 run, 2 over
  int         m_st = 0;
  logic [LL-1:0] m_lane = '0;
  int         m_score = 0;
  int         m_score2 = 0;
  int         m_air = 0;
  int         m_gap = 0;
  logic [7:0] m_lfsr = 8'hA5;
  int         cur_ph = 3;
  vec_t       sb[$];

  function automatic vec_t exp_vec();
    logic a, o, r;
    a = (m_air != 0);
    o = (m_st == 2);
    r = (m_st == 1);
    return {m_lane, 10'(m_score), a, o, r,
            m_lane, 2'(m_score2), a, o, r};
  endfunction

  function automatic vec_t dut_vec();
    return {lane, score, dino_air, game_over, running,
            lane2, score2, dino_air2, game_over2, running2};
  endfunction

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic m_reset();
    m_st = 0; m_lane = '0; m_score = 0; m_score2 = 0;
    m_air = 0; m_gap = 0; m_lfsr = 8'hA5;
    step_base = step_cnt;
    step_base2 = step_cnt2;
  endtask

  task automatic m_adv();
    logic sp, fb;
    if (m_st != 1) return;
    sp = (m_lfsr[1:0] == 2'b00) && (m_gap >= 3);
    if (m_lane[0]) begin
      if (m_score < 1023) m_score++;
      if (m_score2 < 3) m_score2++;
    end
    m_lane = {sp, m_lane[LL-1:1]};
    fb = m_lfsr[0];
    m_lfsr = m_lfsr >> 1;
    if (fb) m_lfsr = m_lfsr ^ 8'hB8;
    m_gap = sp ? 0 : ((m_gap < 3) ? m_gap + 1 : 3);
    if (m_air > 0) m_air--;
  endtask

  task automatic m_settle();
    if (m_st == 1 && m_lane[0] && m_air == 0) m_st = 2;
  endtask

  task automatic op_step(input bit jmp);
    int a0;
    bit was_run;
    tick();
    a0 = m_air;
    was_run = (m_st == 1);
    cur_ph = (cur_ph + 1) % 6;
    phase = 3'(cur_ph);
    jump_btn = jmp;
    m_adv();
    if (jmp && was_run && a0 == 0) m_air = 4;
    m_settle();
    sb.push_back(exp_vec());
    tick();
    jump_btn = 1'b0;
    tick();
    tick();
    @(negedge C);
  endtask

  task automatic op_jump();
    tick();
    jump_btn = 1'b1;
    if (m_st == 1 && m_air == 0) m_air = 4;
    m_settle();
    sb.push_back(exp_vec());
    tick();
    jump_btn = 1'b0;
    tick();
    tick();
    @(negedge C);
  endtask

  task automatic op_start();
    tick();
    start_btn = 1'b1;
    if (m_st != 1) begin
      m_st = 1; m_lane = '0; m_score = 0; m_score2 = 0;
      m_air = 0; m_gap = 0; m_lfsr = 8'hA5;
    end
    sb.push_back(exp_vec());
    tick();
    start_btn = 1'b0;
    tick();
    @(negedge C);
  endtask

  task automatic op_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_reset();
    sb.push_back(exp_vec());
    tick();
    @(negedge C);
  endtask

  task automatic test_reset();
    vec_t e;
    phase = 3'd3;
    cur_ph = 3;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    m_reset();
    sb.push_back(exp_vec());
    repeat (100) tick();
    @(negedge C);
    e = sb.pop_front();
    n_chk++;
    if (dut_vec() !== e)
      $display("FAIL reset_state: got %h want %h", dut_vec(), e);
    else n_pass++;
    n_chk++;
    if (step_cnt + step_cnt2 !== 0)
      $display("FAIL reset_steps: got %0d want 0", step_cnt + step_cnt2);
    else n_pass++;
  endtask

  task automatic test_steps();
    vec_t e;
    int ph[6] = '{3, 4, 5, 0, 1, 2};
    op_start();
    e = sb.pop_front();
    n_chk++;
    if (dut_vec() !== e)
      $display("FAIL start: got %h want %h", dut_vec(), e);
    else n_pass++;
    foreach (ph[i]) begin
      tick();
      phase = 3'(ph[i]);
      if (ph[i] != cur_ph) begin
        m_adv();
        m_settle();
      end
      cur_ph = ph[i];
      repeat (9) tick();
    end
    tick();
    phase = 3'd7;
    repeat (10) tick();
    sb.push_back(exp_vec());
    @(negedge C);
    e = sb.pop_front();
    n_chk++;
    if (dut_vec() !== e)
      $display("FAIL phase_walk: got %h want %h", dut_vec(), e);
    else n_pass++;
    n_chk++;
    if (step_cnt - step_base !== 5 || step_cnt2 - step_base2 !== 5)
      $display("FAIL step_count: got %0d/%0d want 5",
               step_cnt - step_base, step_cnt2 - step_base2);
    else n_pass++;
    n_chk++;
    if (running !== 1'b1)
      $display("FAIL running: got %b want 1", running);
    else n_pass++;
  endtask

  task automatic test_collision();
    vec_t e;
    int sp_i = -1;
    int hit_i = -1;
    int s0;
    op_reset();
    e = sb.pop_front();
    n_chk++;
    if (dut_vec() !== e)
      $display("FAIL coll_reset: got %h want %h", dut_vec(), e);
    else n_pass++;
    op_start();
    void'(sb.pop_front());
    for (int i = 0; i < 300 && m_st == 1; i++) begin
      op_step(1'b0);
      e = sb.pop_front();
      n_chk++;
      if (dut_vec() !== e)
        $display("FAIL scroll: got %h want %h", dut_vec(), e);
      else n_pass++;
      if (sp_i < 0 && lane[LL-1] === 1'b1) sp_i = i;
      if (hit_i < 0 && game_over === 1'b1) hit_i = i;
    end
    n_chk++;
    if (hit_i < 0 || sp_i < 0 || hit_i - sp_i != 15)
      $display("FAIL travel: got %0d want 15 (spawn %0d hit %0d)",
               hit_i - sp_i, sp_i, hit_i);
    else n_pass++;
    n_chk++;
    if (game_over !== 1'b1 || score !== 10'd0)
      $display("FAIL over_state: got over=%b score=%0d want 1/0",
               game_over, score);
    else n_pass++;
    s0 = step_cnt;
    repeat (3) begin
      op_step(1'b0);
      e = sb.pop_front();
      n_chk++;
      if (dut_vec() !== e)
        $display("FAIL frozen: got %h want %h", dut_vec(), e);
      else n_pass++;
    end
    n_chk++;
    if (step_cnt !== s0)
      $display("FAIL over_step: got %0d want %0d", step_cnt, s0);
    else n_pass++;
  endtask

  task automatic test_jump();
    vec_t e;
    bit jumped = 0;
    bit done = 0;
    int n_air = 0;
    op_reset();
    void'(sb.pop_front());
    op_start();
    void'(sb.pop_front());
    for (int i = 0; i < 300 && !done; i++) begin
      if (!jumped && m_lane[1] && m_air == 0) begin
        op_jump();
        e = sb.pop_front();
        n_chk++;
        if (dut_vec() !== e)
          $display("FAIL jump_arm: got %h want %h", dut_vec(), e);
        else n_pass++;
        jumped = 1;
      end
      op_step(1'b0);
      e = sb.pop_front();
      n_chk++;
      if (dut_vec() !== e)
        $display("FAIL jump_run: got %h want %h", dut_vec(), e);
      else n_pass++;
      if (jumped) begin
        n_air++;
        if (dino_air !== 1'b1) done = 1;
      end
    end
    n_chk++;
    if (n_air !== 4)
      $display("FAIL air_steps: got %0d want 4", n_air);
    else n_pass++;
    n_chk++;
    if (score !== 10'd1 || game_over !== 1'b0)
      $display("FAIL cleared: got score=%0d over=%b want 1/0",
               score, game_over);
    else n_pass++;
  endtask

  task automatic test_jump_airborne();
    vec_t e;
    int ops[6] = '{1, 0, 1, 0, 0, 2};
    int i = 0;
    while (i < 300 && !(m_lane[1] && m_air == 0)) begin
      op_step(1'b0);
      e = sb.pop_front();
      n_chk++;
      if (dut_vec() !== e)
        $display("FAIL air_wait: got %h want %h", dut_vec(), e);
      else n_pass++;
      i++;
    end
    n_chk++;
    if (i >= 300)
      $display("FAIL air_timeout: got %0d steps want <300", i);
    else n_pass++;
    foreach (ops[k]) begin
      if (ops[k] == 1) op_jump();
      else op_step(ops[k] == 2);
      e = sb.pop_front();
      n_chk++;
      if (dut_vec() !== e)
        $display("FAIL air_seq%0d: got %h want %h", k, dut_vec(), e);
      else n_pass++;
    end
    n_chk++;
    if (dino_air !== 1'b0 || game_over !== 1'b0)
      $display("FAIL land_jump: got air=%b over=%b want 0/0",
               dino_air, game_over);
    else n_pass++;
  endtask

  task automatic test_saturation();
    vec_t e;
    for (int i = 0; i < 800 && m_score < 5 && m_st == 1; i++) begin
      if (m_lane[1] && m_air == 0) begin
        op_jump();
        void'(sb.pop_front());
      end
      op_step(1'b0);
      e = sb.pop_front();
      n_chk++;
      if (dut_vec() !== e)
        $display("FAIL sat_run: got %h want %h", dut_vec(), e);
      else n_pass++;
    end
    n_chk++;
    if (score !== 10'd5 || score2 !== 2'd3)
      $display("FAIL saturate: got %0d/%0d want 5/3", score, score2);
    else n_pass++;
    for (int i = 0; i < 300 && m_st == 1; i++) begin
      op_step(1'b0);
      void'(sb.pop_front());
    end
    n_chk++;
    if (game_over !== 1'b1 || score2 !== 2'd3)
      $display("FAIL sat_over: got over=%b s2=%0d want 1/3",
               game_over, score2);
    else n_pass++;
    op_start();
    e = sb.pop_front();
    n_chk++;
    if (dut_vec() !== e || running !== 1'b1 || lane !== '0
        || score !== 10'd0 || score2 !== 2'd0)
      $display("FAIL restart: got %h want %h", dut_vec(), e);
    else n_pass++;
    repeat (3) begin
      op_step(1'b0);
      e = sb.pop_front();
      n_chk++;
      if (dut_vec() !== e)
        $display("FAIL rerun: got %h want %h", dut_vec(), e);
      else n_pass++;
    end
    tick();
    rst_n = 1'b0;
    cur_ph = (cur_ph + 1) % 6;
    phase = 3'(cur_ph);
    start_btn = 1'b1;
    jump_btn = 1'b1;
    tick();
    rst_n = 1'b1;
    start_btn = 1'b0;
    jump_btn = 1'b0;
    m_reset();
    @(negedge C);
    n_chk++;
    if (dut_vec() !== 50'd0)
      $display("FAIL mid_reset: got %h want 0", dut_vec());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_steps();
    test_collision();
    test_jump();
    test_jump_airborne();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/obstacle_track.md
Name: obstacle_track

Overview:
Downstream consumer of the slow game-phase counter's 3-bit phase output. Its input cycles 0..5, one change per ~0.1 s.
- Each phase change is one game step.
- On each step, obstacles scroll along a one-dimensional lane toward the dino at cell 0 and new obstacles spawn pseudo-randomly.
- Also runs the dino jump timer, collision detection, score counting and the IDLE/RUN/OVER game state.
- Outputs feed the VGA/LED renderer and the score display.

Parameters:
LANE_LEN, 16, number of lane cells; cell 0 = dino position, cell LANE_LEN-1 = spawn cell
MIN_GAP, 3, minimum steps between two spawns (gap counter saturates here)
AIR_TICKS, 4, steps the dino stays airborne per jump
LFSR_SEED, 8'hA5, LFSR reset/restart value; must be non-zero
SCORE_W, 10, score width

Ports:
C  in  1  system clock (fast clock, same domain as phase counter)
rst_n  in  1  synchronous active-low reset
phase  in  3  phase count from upstream counter, legal 0..5
jump_btn  in  1  jump request, level, pre-synchronised
start_btn  in  1  start/restart request, level, pre-synchronised
lane  out  LANE_LEN  obstacle occupancy, bit i = obstacle in cell i
dino_air  out  1  dino airborne
game_over  out  1  high in OVER state
running  out  1  high in RUN state
score  out  SCORE_W  obstacles cleared, saturating
step  out  1  one-cycle pulse per accepted step in RUN

Behaviour:
- Reset (rst_n=0 at posedge C): state=IDLE; lane=0; score=0; air_cnt=0; gap_cnt=0; lfsr=LFSR_SEED; phase_q<=phase; jump_q=start_q=0. All outputs 0.
- Step detect:
  - raw_step = (phase != phase_q) && (phase <= 5).
  - phase_q updates only when phase <= 5; values 6/7 are ignored and hold phase_q.
  - step output = raw_step && state==RUN, registered-free, same cycle.
- Edge detect: jump_rise = jump_btn & ~jump_q; start_rise = start_btn & ~start_q. Both _q registers update every cycle.
- IDLE: outputs frozen. start_rise -> RUN, clearing lane, score, air_cnt and gap_cnt, and reloading lfsr=LFSR_SEED.
- RUN, in priority order each cycle:
  1. Collision: lane[0] && !dino_air -> OVER next cycle. No shift, no score, no spawn this cycle, even if step is also high.
  2. On step:
     - lane <= {spawn, lane[LANE_LEN-1:1]}.
     - If old lane[0]==1, score += 1, saturating at all-ones.
     - lfsr advances one shift: Galois, taps x^8+x^6+x^5+x^4+1.
     - spawn = (lfsr[1:0]==2'b00) && (gap_cnt >= MIN_GAP), evaluated on the pre-advance lfsr.
     - gap_cnt <= spawn ? 0 : min(gap_cnt+1, MIN_GAP).
     - If air_cnt != 0, air_cnt -= 1.
  3. Jump: jump_rise && air_cnt==0 -> air_cnt <= AIR_TICKS (dino_air high next cycle).
     - Jump while airborne is ignored.
     - Jump_rise coinciding with a step that decrements air_cnt 1->0 is also ignored.
  4. start_rise ignored.
- dino_air = (air_cnt != 0); running = (state==RUN); game_over = (state==OVER).
- OVER: lane, score and air_cnt held, no steps. start_rise -> RUN with the same clearing as from IDLE.
- Reset mid-operation overrides everything, including a same-cycle step or start.

Decomposition:
- Shared package dino_pkg:
  - game state encoding (IDLE=2'd0, RUN=2'd1, OVER=2'd2)
  - PHASE_MAX=3'd5
  - LFSR tap mask 8'hB8
  - default seed
- One sub-module: dino_lfsr (8-bit Galois LFSR with load and enable; sync active-low reset to seed).
- FSM, lane shift, jump timer and score stay in obstacle_track.

Test Plan:
1. Reset with phase=3, then phase held at 3 for 100 cycles -> no step, all outputs 0, state IDLE.
2. start_btn pulse, then phase 3,4,5,0,1,2 each held 10 cycles, then phase=7 -> exactly 5 step pulses (phase=7 gives none), running=1.
3. Force spawn by seed choice (LFSR_SEED such that lfsr[1:0]==0 once gap_cnt reaches 3), no jump -> obstacle reaches lane[0] after 15 more steps; game_over=1 one cycle later; lane frozen; score=0.
4. Same stimulus, jump_btn rising 1 step before the obstacle reaches lane[0] -> dino_air=1 for 4 steps, no collision, score=1 when the obstacle shifts out.
5. Second jump_btn rise while airborne -> ignored; air_cnt continues 3,2,1,0.
6. Score saturation with SCORE_W=2: clear 4 obstacles -> score stays 3. Then, in OVER, start_btn -> RUN, score=0, lane=0. rst_n=0 mid-RUN -> IDLE next edge.
